comma_align_ctrl: RTL and testbench
===================================

Name: comma_align_ctrl

Overview:
- Generates `rxcommaalignen` for one GT receive lane running 1000BASE-X.
- Sits directly upstream of the GPI shifter that places `rxcommaalignen` on GPI bit 10 toward the PS GEM.
- While the lane is unsynchronised it holds comma alignment enabled. It drops the enable after a run of aligned commas, and re-arms on comma loss or a burst of code errors.
- Runs entirely in the GT rx user-clock domain.

Parameters:
- LOCK_CNT, 4: consecutive aligned comma detects required to declare lock (2..15).
- LOSS_TIMEOUT, 1024: cycles in LOCKED with no comma before realign (power of two, 16..65536).
- ERR_THRESH, 4: code-error cycles within one window that force realign (1..15).
- ERR_WINDOW, 256: error-counting window length in cycles (power of two, 16..65536).

Ports:
- clk  in  1  GT rx user clock.
- resetn  in  1  asynchronous active-low reset.
- gt_ready  in  1  GT rx reset-done; asynchronous, synchronised internally.
- rxbyteisaligned  in  1  GT byte-alignment status.
- rxcommadet  in  1  GT comma-detect pulse.
- rxdisperr  in  2  per-byte disparity error.
- rxnotintable  in  2  per-byte not-in-table error.
- rxcommaalignen_out  out  1  comma alignment enable; feeds the GPI shifter input.
- aligned  out  1  lane locked status.
- realign_count  out  8  saturating count of LOCKED->SEARCH transitions.

Behaviour:
- Reset (`resetn` low, asynchronous): state IDLE, all counters 0. `rxcommaalignen_out` = 0, `aligned` = 0, `realign_count` = 0.
- Deassertion of `resetn` is assumed synchronised externally.
- `gt_ready` passes through a 2-flop synchroniser; `gt_ready_s` is the synchronised value.
- All other inputs are synchronous to `clk`.
- States are IDLE, SEARCH and LOCKED. Outputs are Moore outputs decoded from the state register, with no combinational path from inputs:
  - `rxcommaalignen_out` = (state == SEARCH).
  - `aligned` = (state == LOCKED).
- IDLE -> SEARCH when `gt_ready_s` = 1. `rxcommaalignen_out` rises 3 clk edges after `gt_ready` is first sampled high.
- Any state -> IDLE when `gt_ready_s` = 0. This has priority over every other transition, clears all counters, and does not increment `realign_count`.
- SEARCH:
  - `lock_cnt` increments on cycles where `rxcommadet` & `rxbyteisaligned`.
  - `lock_cnt` clears on any cycle with `rxbyteisaligned` = 0; this clear wins over a simultaneous commadet.
  - Go to LOCKED on the cycle the increment makes `lock_cnt` == LOCK_CNT.
  - On entry to LOCKED: `lock_cnt`, `loss_cnt`, `err_cnt` and `win_cnt` are all cleared.
- LOCKED, comma-loss timer:
  - `loss_cnt` clears on `rxcommadet`, otherwise increments.
  - Realign when `loss_cnt` reaches LOSS_TIMEOUT-1 without a commadet.
- LOCKED, error window:
  - `win_cnt` free-runs modulo ERR_WINDOW.
  - `err_cnt` increments on any cycle with |(`rxdisperr` | `rxnotintable`); both bytes in error count as one.
  - `err_cnt` clears when `win_cnt` wraps to 0. If an error occurs in the wrap cycle, `err_cnt` becomes 1.
  - Realign when the increment makes `err_cnt` == ERR_THRESH.
- Realign action: LOCKED -> SEARCH, and `realign_count` += 1, saturating at 255.
  - If timeout and error threshold fire in the same cycle, exactly one increment occurs.
  - A comma with an error in the same cycle still clears `loss_cnt`.
- `rxbyteisaligned` is ignored in LOCKED; loss of lock is detected only by timeout or errors.
- Counter widths: `clog2` of the bound. Compares are exact; no wrap past the threshold is possible.

Decomposition:
- Package `comma_align_pkg` holds:
  - the state enum (IDLE, SEARCH, LOCKED, 2 bits);
  - the counter-width localparam functions;
  - the saturating-count width (8).
- One sub-module, `sync_2ff`: a generic 2-flop synchroniser with asynchronous active-low reset, used for `gt_ready`.
- Everything else stays flat in `comma_align_ctrl`.

Test Plan:
- Reset then `gt_ready` = 1 with `rxbyteisaligned` = 1 -> `rxcommaalignen_out` 0 during reset, rises exactly 3 edges after `gt_ready`; 4 commadet pulses -> `aligned` = 1 and `rxcommaalignen_out` = 0 on the cycle after the 4th.
- In SEARCH: 3 aligned commas, then `rxbyteisaligned` = 0 for 1 cycle, then 3 commas -> no lock; a 4th comma -> lock.
- LOCKED with commas stopped (LOSS_TIMEOUT = 1024) -> SEARCH exactly 1024 cycles after the last commadet, `realign_count` = 1; a commadet at cycle 1023 prevents the transition.
- LOCKED with 3 error cycles, then window wrap, then 3 more -> remains LOCKED; 4 errors within one window -> SEARCH, `realign_count` increments by 1. Drive the timeout and the 4th error in the same cycle -> single increment.
- Force 300 realign cycles -> `realign_count` saturates at 255. Drop `gt_ready` while LOCKED -> IDLE after 2 sync edges, both outputs 0, count unchanged.
- Assert `resetn` low mid-SEARCH -> outputs and all counters 0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/comma_align_pkg.sv
// Shared types and sizing helpers for the comma alignment controller.
package comma_align_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int SAT_W = 8;

   // Width for a counter that must hold values 0..bound.
   function automatic int cnt_w(input int bound);
      return (bound < 2) ? 1 : $clog2(bound + 1);
   endfunction

   // Width for a counter that runs 0..bound-1 (modulo bound).
   function automatic int mod_w(input int bound);
      return (bound < 2) ? 1 : $clog2(bound);
   endfunction

endpackage

// File: rtl/comma_align_ctrl_sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-low reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/comma_align_ctrl.sv
// Drives rxcommaalignen for one 1000BASE-X GT lane: enabled while searching,
// dropped after a run of aligned commas, re-armed on comma loss or error bursts.
module comma_align_ctrl
   import comma_align_pkg::*;
#(
   parameter int LOCK_CNT     = 4,
   parameter int LOSS_TIMEOUT = 1024,
   parameter int ERR_THRESH   = 4,
   parameter int ERR_WINDOW   = 256
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             gt_ready,
   input  logic             rxbyteisaligned,
   input  logic             rxcommadet,
   input  logic [1:0]       rxdisperr,
   input  logic [1:0]       rxnotintable,
   output logic             rxcommaalignen_out,
   output logic             aligned,
   output logic [SAT_W-1:0] realign_count
);

   localparam int LOCK_W = cnt_w(LOCK_CNT);
   localparam int LOSS_W = mod_w(LOSS_TIMEOUT);
   localparam int ERR_W  = cnt_w(ERR_THRESH);
   localparam int WIN_W  = mod_w(ERR_WINDOW);

   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CNT - 1);
   localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);
   localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(ERR_THRESH - 1);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(ERR_WINDOW - 1);

   logic              gt_ready_s;
   state_t            state, state_nxt;
   logic [LOCK_W-1:0] lock_cnt, lock_nxt;
   logic [LOSS_W-1:0] loss_cnt, loss_nxt;
   logic [ERR_W-1:0]  err_cnt, err_nxt, err_base;
   logic [WIN_W-1:0]  win_cnt, win_nxt;
   logic [SAT_W-1:0]  count_nxt;
   logic              err_any, err_hit, loss_hit;

   sync_2ff #(.WIDTH(1)) u_sync_ready (
      .clk    (clk),
      .resetn (resetn),
      .d      (gt_ready),
      .q      (gt_ready_s)
   );

   assign rxcommaalignen_out = (state == SEARCH);
   assign aligned            = (state == LOCKED);

   // The error window restarts on the wrap cycle, so an error there counts as the first.
   assign err_any  = |(rxdisperr | rxnotintable);
   assign err_base = (win_cnt == WIN_LAST) ? '0 : err_cnt;
   assign err_hit  = err_any && (err_base == ERR_LAST);
   assign loss_hit = !rxcommadet && (loss_cnt == LOSS_LAST);

   always_comb begin
      state_nxt = state;
      lock_nxt  = lock_cnt;
      loss_nxt  = loss_cnt;
      err_nxt   = err_cnt;
      win_nxt   = win_cnt;
      count_nxt = realign_count;
      if (!gt_ready_s) begin
         state_nxt = IDLE;
         lock_nxt  = '0;
         loss_nxt  = '0;
         err_nxt   = '0;
         win_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = SEARCH;
               lock_nxt  = '0;
               loss_nxt  = '0;
               err_nxt   = '0;
               win_nxt   = '0;
            end
            SEARCH: begin
               if (!rxbyteisaligned) begin
                  lock_nxt = '0;
               end else if (rxcommadet) begin
                  if (lock_cnt == LOCK_LAST) begin
                     state_nxt = LOCKED;
                     lock_nxt  = '0;
                     loss_nxt  = '0;
                     err_nxt   = '0;
                     win_nxt   = '0;
                  end else begin
                     lock_nxt = lock_cnt + 1'b1;
                  end
               end
            end
            LOCKED: begin
               win_nxt  = win_cnt + 1'b1;
               loss_nxt = rxcommadet ? '0 : loss_cnt + 1'b1;
               err_nxt  = err_base + ERR_W'(err_any);
               // Timeout and error burst in the same cycle are a single realign.
               if (loss_hit || err_hit) begin
                  state_nxt = SEARCH;
                  lock_nxt  = '0;
                  loss_nxt  = '0;
                  err_nxt   = '0;
                  win_nxt   = '0;
                  if (realign_count != '1) begin
                     count_nxt = realign_count + 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         lock_cnt      <= '0;
         loss_cnt      <= '0;
         err_cnt       <= '0;
         win_cnt       <= '0;
         realign_count <= '0;
      end else begin
         state         <= state_nxt;
         lock_cnt      <= lock_nxt;
         loss_cnt      <= loss_nxt;
         err_cnt       <= err_nxt;
         win_cnt       <= win_nxt;
         realign_count <= count_nxt;
      end
   end

endmodule

// File: tb/tb_comma_align_ctrl.sv
// Directed bench for comma_align_ctrl with default parameters.
module tb_comma_align_ctrl;

   logic       clk;
   logic       resetn;
   logic       gt_ready;
   logic       rxbyteisaligned;
   logic       rxcommadet;
   logic [1:0] rxdisperr;
   logic [1:0] rxnotintable;
   logic       rxcommaalignen_out;
   logic       aligned;
   logic [7:0] realign_count;

   int n_tests = 0;
   int n_fail  = 0;

   comma_align_ctrl dut (
      .clk                (clk),
      .resetn             (resetn),
      .gt_ready           (gt_ready),
      .rxbyteisaligned    (rxbyteisaligned),
      .rxcommadet         (rxcommadet),
      .rxdisperr          (rxdisperr),
      .rxnotintable       (rxnotintable),
      .rxcommaalignen_out (rxcommaalignen_out),
      .aligned            (aligned),
      .realign_count      (realign_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample 1ns after the rising edge.
   task automatic cyc(input logic cd, input logic ba, input logic [1:0] de, input logic [1:0] nit);
      rxcommadet      = cd;
      rxbyteisaligned = ba;
      rxdisperr       = de;
      rxnotintable    = nit;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic e;
      resetn          = 1'b0;
      gt_ready        = 1'b0;
      rxbyteisaligned = 1'b0;
      rxcommadet      = 1'b0;
      rxdisperr       = 2'b00;
      rxnotintable    = 2'b00;
      #1;
      check("rst_en",    8'(rxcommaalignen_out), 8'd0);
      check("rst_align", 8'(aligned),            8'd0);
      check("rst_count", realign_count,          8'd0);

      gt_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_en", 8'(rxcommaalignen_out), 8'd0);

      resetn = 1'b1;
      cyc(1'b0, 1'b1, 2'b00, 2'b00);
      check("ready_e1", 8'(rxcommaalignen_out), 8'd0);
      cyc(1'b0, 1'b1, 2'b00, 2'b00);
      check("ready_e2", 8'(rxcommaalignen_out), 8'd0);
      cyc(1'b0, 1'b1, 2'b00, 2'b00);
      check("ready_e3", 8'(rxcommaalignen_out), 8'd1);

      repeat (3) cyc(1'b1, 1'b1, 2'b00, 2'b00);
      check("lock_3", 8'(aligned), 8'd0);
      cyc(1'b1, 1'b1, 2'b00, 2'b00);
      check("lock_4_align", 8'(aligned),            8'd1);
      check("lock_4_en",    8'(rxcommaalignen_out), 8'd0);

      // Error window: 3 errors, wrap at 256 (error there restarts count at 1), then more.
      for (int k = 1; k <= 259; k++) begin
         e = (k <= 3) || (k >= 256);
         if (k == 1)        cyc(1'b1, 1'b1, 2'b11, 2'b11);
         else if (k == 257) cyc(1'b1, 1'b1, 2'b00, 2'b10);
         else               cyc(1'b1, 1'b1, e ? 2'b01 : 2'b00, 2'b00);
         if (k == 255) check("win_pre_wrap", 8'(aligned), 8'd1);
         if (k == 258) check("win_3_after",  8'(aligned), 8'd1);
      end
      check("win_4_align", 8'(aligned),            8'd0);
      check("win_4_en",    8'(rxcommaalignen_out), 8'd1);
      check("win_4_count", realign_count,          8'd1);

      repeat (3) cyc(1'b1, 1'b1, 2'b00, 2'b00);
      check("gap_pre", 8'(aligned), 8'd0);
      cyc(1'b1, 1'b0, 2'b00, 2'b00);
      check("gap_clear_wins", 8'(aligned), 8'd0);
      repeat (3) cyc(1'b1, 1'b1, 2'b00, 2'b00);
      check("gap_3", 8'(aligned), 8'd0);
      cyc(1'b1, 1'b1, 2'b00, 2'b00);
      check("gap_lock",  8'(aligned),   8'd1);
      check("gap_count", realign_count, 8'd1);

      // Comma loss: a comma at 1023 saves the lock; the next loss fires 1024 later.
      for (int k = 1; k <= 2047; k++) begin
         cyc(k == 1023, 1'b1, 2'b00, 2'b00);
         if (k == 1024) check("loss_saved",     8'(aligned), 8'd1);
         if (k == 2046) check("loss_edge_m1",   8'(aligned), 8'd1);
      end
      check("loss_align", 8'(aligned),            8'd0);
      check("loss_en",    8'(rxcommaalignen_out), 8'd1);
      check("loss_count", realign_count,          8'd2);

      // Timeout and 4th error land together at k=1034.
      repeat (4) cyc(1'b1, 1'b1, 2'b00, 2'b00);
      check("both_lock", 8'(aligned), 8'd1);
      for (int k = 1; k <= 1034; k++) begin
         e = (k >= 1031);
         cyc(k <= 10, 1'b1, e ? 2'b01 : 2'b00, 2'b00);
         if (k == 1033) check("both_pre", 8'(aligned), 8'd1);
      end
      check("both_align", 8'(aligned),   8'd0);
      check("both_count", realign_count, 8'd3);

      for (int it = 0; it < 300; it++) begin
         repeat (4) cyc(1'b1, 1'b1, 2'b00, 2'b00);
         repeat (4) cyc(1'b0, 1'b1, 2'b01, 2'b00);
         if (it == 250) check("sat_254", realign_count, 8'd254);
      end
      check("sat_255", realign_count,          8'd255);
      check("sat_en",  8'(rxcommaalignen_out), 8'd1);

      repeat (4) cyc(1'b1, 1'b1, 2'b00, 2'b00);
      check("drop_locked", 8'(aligned), 8'd1);
      gt_ready = 1'b0;
      cyc(1'b0, 1'b1, 2'b00, 2'b00);
      check("drop_e1", 8'(aligned), 8'd1);
      cyc(1'b0, 1'b1, 2'b00, 2'b00);
      check("drop_e2", 8'(aligned), 8'd1);
      cyc(1'b0, 1'b1, 2'b00, 2'b00);
      check("drop_e3_align", 8'(aligned),            8'd0);
      check("drop_e3_en",    8'(rxcommaalignen_out), 8'd0);
      check("drop_e3_count", realign_count,          8'd255);
      cyc(1'b1, 1'b1, 2'b00, 2'b00);
      check("drop_idle", 8'(rxcommaalignen_out), 8'd0);

      gt_ready = 1'b1;
      repeat (3) cyc(1'b0, 1'b1, 2'b00, 2'b00);
      check("rearm_en", 8'(rxcommaalignen_out), 8'd1);
      repeat (2) cyc(1'b1, 1'b1, 2'b00, 2'b00);
      #2;
      resetn = 1'b0;
      #1;
      check("async_en",    8'(rxcommaalignen_out), 8'd0);
      check("async_align", 8'(aligned),            8'd0);
      check("async_count", realign_count,          8'd0);

      @(posedge clk);
      #1;
      resetn = 1'b1;
      repeat (2) cyc(1'b0, 1'b1, 2'b00, 2'b00);
      check("post_rst_e2", 8'(rxcommaalignen_out), 8'd0);
      cyc(1'b0, 1'b1, 2'b00, 2'b00);
      check("post_rst_e3", 8'(rxcommaalignen_out), 8'd1);
      repeat (3) cyc(1'b1, 1'b1, 2'b00, 2'b00);
      check("post_rst_3", 8'(aligned), 8'd0);
      cyc(1'b1, 1'b1, 2'b00, 2'b00);
      check("post_rst_lock",  8'(aligned),   8'd1);
      check("post_rst_count", realign_count, 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
